// File: rtl/fir_inverse_filter.sv
// All-pole inverse of a monic FIR: x_hat[n] = y[n] - sum c[i]*x_hat[n-i], one MAC per cycle.
// Accepts one sample in IDLE, accumulates N-1 products, then holds the saturated result.
module fir_inverse_filter #(
    parameter int unsigned N    = 16,
    parameter int unsigned FRAC = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic signed [15:0] y_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] coeffs [0:N-1],
    output logic signed [15:0] x_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sat
);

    localparam int unsigned ACC_W = 17 + FRAC + $clog2(N) + 1;
    localparam int unsigned RW    = ACC_W - FRAC;
    localparam int unsigned IW    = $clog2(N);

    localparam logic signed [RW-1:0] MaxV = RW'(32767);
    localparam logic signed [RW-1:0] MinV = RW'(-32768);

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic        [IW-1:0]     idx_q, idx_d;
    logic signed [15:0]       hist_q [N-1];
    logic signed [15:0]       hist_d [N-1];
    logic signed [15:0]       x_q, x_d;
    logic                     sat_q, sat_d;
    logic                     valid_q, valid_d;
    logic                     alive_q;

    logic        [IW-1:0]     hidx;
    logic signed [31:0]       prod;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [RW-1:0]     r;
    logic                     r_hi, r_lo;
    logic signed [15:0]       x_sat;

    // hist_q[k] holds x_hat[n-1-k]; tap i pairs with hist_q[i-1]
    assign hidx     = idx_q - IW'(1);
    assign prod     = coeffs[idx_q] * hist_q[hidx];
    assign acc_next = acc_q - $signed({{(ACC_W-32){prod[31]}}, prod});
    assign r        = RW'(acc_next >>> FRAC);
    assign r_hi     = (r > MaxV);
    assign r_lo     = (r < MinV);
    assign x_sat    = r_hi ? 16'sh7fff : (r_lo ? 16'sh8000 : r[15:0]);

    // alive_q keeps in_ready low until the first edge after reset release
    assign in_ready  = alive_q && (state_q == StIdle) && !clr;
    assign x_out     = x_q;
    assign out_sat   = sat_q;
    assign out_valid = valid_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        hist_d  = hist_q;
        x_d     = x_q;
        sat_d   = sat_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (clr) begin
                    for (int k = 0; k < N - 1; k++) begin
                        hist_d[k] = '0;
                    end
                end else if (in_valid && alive_q) begin
                    acc_d   = {{(ACC_W-16){y_in[15]}}, y_in} <<< FRAC;
                    idx_d   = IW'(1);
                    state_d = StMac;
                end
            end
            StMac: begin
                acc_d = acc_next;
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(N - 1)) begin
                    x_d       = x_sat;
                    sat_d     = r_hi || r_lo;
                    valid_d   = 1'b1;
                    hist_d[0] = x_sat;
                    for (int k = 1; k < N - 1; k++) begin
                        hist_d[k] = hist_q[k-1];
                    end
                    idx_d   = IW'(1);
                    state_d = StOut;
                end
            end
            StOut: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            idx_q   <= IW'(1);
            x_q     <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            alive_q <= 1'b0;
            for (int k = 0; k < N - 1; k++) begin
                hist_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            alive_q <= 1'b1;
            hist_q  <= hist_d;
        end
    end

endmodule

// File: tb/tb_fir_inverse_filter.sv
// Scoreboarded bench for fir_inverse_filter (N=4, FRAC=14): directed scenarios then random
// traffic with random backpressure, checked against an arithmetic deconvolution model.
module tb_fir_inverse_filter;

    localparam int N    = 4;
    localparam int FRAC = 14;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               clr = 1'b0;
    logic signed [15:0] y_in = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] coeffs [0:N-1];
    logic signed [15:0] x_out;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               out_sat;

    fir_inverse_filter #(.N(N), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .y_in      (y_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coeffs    (coeffs),
        .x_out     (x_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        bit s;
    } exp_t;

    exp_t exp_q[$];
    int   acc_edge_q[$];
    int   hist_m [1:N-1];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   rand_or = 1'b0;
    bit   prev_valid = 1'b0;
    logic signed [15:0] held_x;
    logic               held_s;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // x_hat = floor((y*2^FRAC - sum c[i]*x_hat[n-i]) / 2^FRAC), clamped to 16 bits
    function automatic exp_t model_step(input int y);
        exp_t   e;
        longint acc;
        longint r;
        acc = longint'(y) * (longint'(1) << FRAC);
        for (int i = 1; i < N; i++) begin
            acc = acc - longint'(coeffs[i]) * longint'(hist_m[i]);
        end
        r = acc / (longint'(1) << FRAC);
        if ((acc % (longint'(1) << FRAC)) != 0 && acc < 0) r = r - 1;
        e.s = (r > 32767) || (r < -32768);
        e.x = (r > 32767) ? 32767 : ((r < -32768) ? -32768 : int'(r));
        for (int k = N - 1; k >= 2; k--) hist_m[k] = hist_m[k-1];
        hist_m[1] = e.x;
        return e;
    endfunction

    function automatic void model_clear();
        for (int k = 1; k < N; k++) hist_m[k] = 0;
    endfunction

    // Monitor: latency, hold-under-backpressure and scoreboard compare at each handshake
    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_edge_q.push_back(cyc + 1);
            if (out_valid) begin
                if (!prev_valid) begin
                    held_x = x_out;
                    held_s = out_sat;
                    if (acc_edge_q.size() > 0)
                        check("latency", cyc + 1 - acc_edge_q.pop_front(), N);
                    else
                        check("output_without_accept", 1, 0);
                end else begin
                    check("held_x_out", x_out, held_x);
                    check("held_out_sat", out_sat, held_s);
                end
                check("in_ready_while_out_valid", in_ready, 0);
                if (out_ready) begin
                    if (exp_q.size() > 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("x_out", x_out, e.x);
                        check("out_sat", out_sat, e.s);
                    end else begin
                        check("unexpected_output", 1, 0);
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Call #1 after a posedge; returns #1 after the accepting posedge
    task automatic send(input int y);
        bit ok;
        ok = 1'b0;
        y_in = 16'(y);
        in_valid = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(model_step(y));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        if (!seen) check("out_valid_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_x_out", x_out, 0);
        check("rst_in_ready", in_ready, 0);
        exp_q.delete();
        acc_edge_q.delete();
        model_clear();
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_release", in_ready, 1);
    endtask

    task automatic clear_hist();
        clr = 1'b1;
        y_in = 16'sd123;
        in_valid = 1'b1;
        @(negedge clk);
        check("clr_blocks_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        model_clear();
    endtask

    task automatic set_c(input int c0, input int c1, input int c2, input int c3);
        coeffs[0] = 16'(c0);
        coeffs[1] = 16'(c1);
        coeffs[2] = 16'(c2);
        coeffs[3] = 16'(c3);
    endtask

    initial begin
        set_c(0, 0, 0, 0);
        model_clear();
        #1;
        check("init_out_valid", out_valid, 0);
        check("init_x_out", x_out, 0);
        check("init_in_ready", in_ready, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_first_cycle", in_ready, 1);

        // Reset while an output is stalled, then plain pass-through
        set_c(0, 4096, 0, 0);
        out_ready = 1'b0;
        send(1234);
        wait_valid();
        @(posedge clk);
        #1;
        do_reset();
        out_ready = 1'b1;
        set_c(0, 0, 0, 0);
        send(100);
        drain();

        // Inversion with c[1]=0.5
        set_c(0, 8192, 0, 0);
        send(1000);
        send(500);
        send(0);
        drain();

        // Clear wins over in_valid; fresh history afterwards
        clear_hist();
        send(700);
        drain();

        // Saturation with c[1]=-1.0
        clear_hist();
        set_c(0, -16384, 0, 0);
        send(20000);
        send(20000);
        send(-32768);
        drain();

        // Backpressure: hold 5 cycles, then handshake and immediate re-accept
        set_c(0, 8192, -4096, 2048);
        out_ready = 1'b0;
        send(3000);
        wait_valid();
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_handshake", in_ready, 1);
        check("out_valid_after_handshake", out_valid, 0);
        send(-2500);
        drain();

        // Reset two edges into MAC; post-reset result proves history was wiped
        send(9999);
        @(posedge clk);
        #1;
        do_reset();
        set_c(0, 8192, 4096, 2048);
        repeat (3) @(posedge clk);
        #1;
        send(5);
        drain();

        // Random traffic, random coefficients and random backpressure
        for (int b = 0; b < 6; b++) begin
            set_c($urandom_range(0, 65535) - 32768, $urandom_range(0, 16383) - 8192,
                  $urandom_range(0, 16383) - 8192, $urandom_range(0, 16383) - 8192);
            if (b % 2 == 1) clear_hist();
            rand_or = 1'b1;
            for (int s = 0; s < 10; s++) begin
                send($urandom_range(0, 65535) - 32768);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #0;
            end
            rand_or = 1'b0;
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            drain();
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
